// File: rtl/op_calc_if.sv
// Operand-in / result-out handshake bundle for op_calc.
// Master drives operands and result acceptance; slave is the calculator.
interface op_calc_if;
   logic        a_valid;
   logic [31:0] a_data;
   logic        a_ready;
   logic [2:0]  b_operation;
   logic        b_valid;
   logic [31:0] b_result;
   logic        b_ready;

   modport master (
      output a_valid, a_data, b_operation, b_ready,
      input  a_ready, b_valid, b_result
   );

   modport slave (
      input  a_valid, a_data, b_operation, b_ready,
      output a_ready, b_valid, b_result
   );
endinterface

// File: rtl/op_calc.sv
// Multi-operand calculator: collects 2 or NRED operands, then presents one result.
// Define OP_CALC_STATS_EN to add the res_count handshake counter port.
module op_calc #(
   parameter int NRED = 4
) (
   input  logic      clk,
   input  logic      rstn,
   op_calc_if.slave  bus
`ifdef OP_CALC_STATS_EN
   ,
   output logic [15:0] res_count
`endif
);

   localparam int LOGN = $clog2(NRED);
   localparam int ACCW = 32 + LOGN;
   localparam int CW   = LOGN + 1;

   localparam logic [2:0] OP_SUB2 = 3'd1;
   localparam logic [2:0] OP_OR2  = 3'd2;
   localparam logic [2:0] OP_AND2 = 3'd3;
   localparam logic [2:0] OP_OR   = 3'd4;
   localparam logic [2:0] OP_AND  = 3'd5;
   localparam logic [2:0] OP_AVG  = 3'd7;

   typedef enum logic {COLLECT, OUT} state_t;

   state_t          state_q, state_d;
   logic [2:0]      op_q;
   logic [CW-1:0]   count_q;
   logic [ACCW-1:0] acc_q;

   logic            accept;
   logic            handshake;
   logic            last;
   logic [2:0]      cur_op;
   logic [CW-1:0]   need;
   logic [ACCW-1:0] opnd;
   logic [ACCW-1:0] combined;

   assign accept    = bus.a_valid && bus.a_ready;
   assign handshake = bus.b_valid && bus.b_ready;

   // The first operand's opcode is still on the bus, later ones use the latched copy.
   assign cur_op = (count_q == '0) ? bus.b_operation : op_q;
   assign need   = (cur_op >= OP_OR) ? CW'(NRED) : CW'(2);
   assign last   = (count_q == need - CW'(1));
   assign opnd   = {{LOGN{1'b0}}, bus.a_data};

   // Wide accumulator keeps AVG's carries; other ops only present the low 32 bits.
   always_comb begin
      combined = acc_q + opnd;
      case (op_q)
         OP_SUB2:         combined = acc_q - opnd;
         OP_OR2, OP_OR:   combined = acc_q | opnd;
         OP_AND2, OP_AND: combined = acc_q & opnd;
         default:         combined = acc_q + opnd;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= COLLECT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         COLLECT: if (accept && last) state_d = OUT;
         OUT:     if (handshake)      state_d = COLLECT;
         default:                     state_d = COLLECT;
      endcase
   end

   always_comb begin
      bus.a_ready = (state_q == COLLECT);
      bus.b_valid = (state_q == OUT);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         op_q    <= '0;
         count_q <= '0;
         acc_q   <= '0;
      end else if (accept) begin
         if (count_q == '0) begin
            op_q  <= bus.b_operation;
            acc_q <= opnd;
         end else begin
            acc_q <= combined;
         end
         count_q <= last ? '0 : count_q + CW'(1);
      end
   end

   assign bus.b_result = (op_q == OP_AVG) ? acc_q[ACCW-1:LOGN] : acc_q[31:0];

`ifdef OP_CALC_STATS_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)          res_count <= '0;
      else if (handshake) res_count <= res_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_op_calc.sv
// Directed self-checking bench for op_calc with a transaction-level reference model.
module tb_op_calc;

   localparam int NRED = 4;

   logic clk;
   logic rstn;
   int   vectors = 0;
   int   errors  = 0;

   op_calc_if bus ();

`ifdef OP_CALC_STATS_EN
   logic [15:0] res_count;
   logic [15:0] m_stats;
`endif

   op_calc #(.NRED(NRED)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
`ifdef OP_CALC_STATS_EN
      ,
      .res_count (res_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] opnd_m [16];
   int          m_n    = 0;
   logic [2:0]  m_op   = '0;
   logic        m_busy = 1'b0;
   logic [31:0] m_res  = '0;

   // Result of a whole transaction computed from the operation definitions.
   function automatic logic [31:0] expected_result(input logic [2:0] op, input int n);
      logic [63:0] sum;
      logic [31:0] r;
      r   = opnd_m[0];
      sum = 64'(opnd_m[0]);
      for (int i = 1; i < n; i++) begin
         case (op)
            3'd0, 3'd6: r = r + opnd_m[i];
            3'd1:       r = r - opnd_m[i];
            3'd2, 3'd4: r = r | opnd_m[i];
            3'd3, 3'd5: r = r & opnd_m[i];
            default:    sum = sum + 64'(opnd_m[i]);
         endcase
      end
      if (op == 3'd7) r = 32'(sum / 64'(n));
      return r;
   endfunction

   always @(posedge clk) begin
      if (!rstn) begin
         m_busy = 1'b0;
         m_n    = 0;
         m_res  = '0;
`ifdef OP_CALC_STATS_EN
         m_stats = '0;
`endif
      end else if (!m_busy) begin
         if (bus.a_valid) begin
            if (m_n == 0) m_op = bus.b_operation;
            opnd_m[m_n] = bus.a_data;
            m_n++;
            if (m_n == ((m_op >= 3'd4) ? NRED : 2)) begin
               m_res  = expected_result(m_op, m_n);
               m_busy = 1'b1;
               m_n    = 0;
            end
         end
      end else if (bus.b_ready) begin
         m_busy = 1'b0;
`ifdef OP_CALC_STATS_EN
         m_stats = m_stats + 16'd1;
`endif
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rstn) begin
         checkOutput("rst_a_ready",  32'(bus.a_ready), 32'd1);
         checkOutput("rst_b_valid",  32'(bus.b_valid), 32'd0);
         checkOutput("rst_b_result", bus.b_result,     32'd0);
`ifdef OP_CALC_STATS_EN
         checkOutput("rst_res_count", 32'(res_count), 32'd0);
`endif
      end else begin
         checkOutput("a_ready", 32'(bus.a_ready), 32'(!m_busy));
         checkOutput("b_valid", 32'(bus.b_valid), 32'(m_busy));
         if (m_busy) checkOutput("b_result", bus.b_result, m_res);
`ifdef OP_CALC_STATS_EN
         checkOutput("res_count", 32'(res_count), 32'(m_stats));
`endif
      end
   end

   // Drives one cycle of inputs, returning just after the next rising edge.
   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [2:0] op,
                                input logic rdy);
      bus.a_valid     = v;
      bus.a_data      = d;
      bus.b_operation = op;
      bus.b_ready     = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic pulseReset();
      rstn = 1'b0;
      applyStimulus(1'b0, 32'h0, 3'd0, 1'b0);
      applyStimulus(1'b0, 32'h0, 3'd0, 1'b0);
      rstn = 1'b1;
   endtask

   // Waits for a result, pins it to a literal, holds it, then completes the handshake
   // while offering a stray operand that must not be taken.
   task automatic waitResult(input string name, input logic [31:0] exp, input int hold);
      int t = 0;
      while (!bus.b_valid && t < 10) begin
         applyStimulus(1'b0, 32'h0, 3'd0, 1'b0);
         t++;
      end
      checkOutput({name, "_valid"}, 32'(bus.b_valid), 32'd1);
      checkOutput({name, "_lit"},   bus.b_result,     exp);
      for (int i = 0; i < hold; i++) applyStimulus(1'b0, 32'h0, 3'd0, 1'b0);
      applyStimulus(1'b1, 32'hDEAD_BEEF, 3'd6, 1'b1);
      checkOutput({name, "_done"},  32'(bus.b_valid), 32'd0);
   endtask

   initial begin
      rstn = 1'b1;
      bus.a_valid = 1'b0; bus.a_data = '0; bus.b_operation = '0; bus.b_ready = 1'b0;
      #1 rstn = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 3'd0, 1'b0);
      rstn = 1'b1;
      applyStimulus(1'b0, 32'h0, 3'd0, 1'b0);

      // ADD2 wrap with b_ready already high
      applyStimulus(1'b1, 32'hFFFF_FFFF, 3'd0, 1'b1);
      applyStimulus(1'b1, 32'h0000_0002, 3'd0, 1'b1);
      waitResult("add2", 32'h0000_0001, 0);

      applyStimulus(1'b1, 32'd5, 3'd1, 1'b0);
      applyStimulus(1'b1, 32'd7, 3'd1, 1'b0);
      waitResult("sub2", 32'hFFFF_FFFE, 1);

      applyStimulus(1'b1, 32'h0000_00F0, 3'd2, 1'b0);
      applyStimulus(1'b1, 32'h0000_000F, 3'd2, 1'b0);
      waitResult("or2", 32'h0000_00FF, 0);

      applyStimulus(1'b1, 32'hFFFF_FFFF, 3'd7, 1'b0);
      applyStimulus(1'b1, 32'hFFFF_FFFF, 3'd7, 1'b0);
      applyStimulus(1'b1, 32'hFFFF_FFFF, 3'd7, 1'b0);
      applyStimulus(1'b1, 32'h0000_0003, 3'd7, 1'b0);
      waitResult("avg_big", 32'hC000_0000, 0);

      for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 32'(i), 3'd7, 1'b0);
      waitResult("avg_floor", 32'd2, 0);

      // OR with gaps while the opcode bus switches to AND
      applyStimulus(1'b1, 32'h1, 3'd4, 1'b0);
      applyStimulus(1'b0, 32'h0, 3'd5, 1'b0);
      applyStimulus(1'b0, 32'hFF, 3'd5, 1'b0);
      applyStimulus(1'b1, 32'h2, 3'd5, 1'b0);
      applyStimulus(1'b0, 32'h0, 3'd5, 1'b0);
      applyStimulus(1'b1, 32'h4, 3'd5, 1'b0);
      applyStimulus(1'b1, 32'h8, 3'd5, 1'b0);
      waitResult("or_gaps", 32'h0000_000F, 0);

      applyStimulus(1'b1, 32'hFFFF_FFFF, 3'd5, 1'b0);
      applyStimulus(1'b1, 32'hFF00_FF00, 3'd5, 1'b0);
      applyStimulus(1'b1, 32'hF0F0_F0F0, 3'd5, 1'b0);
      applyStimulus(1'b1, 32'h3C3C_3C3C, 3'd5, 1'b0);
      waitResult("and4", 32'h3000_3000, 0);

      applyStimulus(1'b1, 32'h8000_0000, 3'd6, 1'b0);
      applyStimulus(1'b1, 32'h8000_0000, 3'd6, 1'b0);
      applyStimulus(1'b1, 32'd5, 3'd6, 1'b0);
      applyStimulus(1'b1, 32'd6, 3'd6, 1'b0);
      waitResult("sum_wrap", 32'h0000_000B, 0);

      // AND2 result held back for five cycles
      applyStimulus(1'b1, 32'hF0F0_1234, 3'd3, 1'b0);
      applyStimulus(1'b1, 32'h0FF0_FF00, 3'd3, 1'b0);
      waitResult("and2_hold", 32'h00F0_1200, 5);

      // Reset while a result is pending discards it
      applyStimulus(1'b1, 32'd100, 3'd0, 1'b0);
      applyStimulus(1'b1, 32'd200, 3'd0, 1'b0);
      applyStimulus(1'b0, 32'h0, 3'd0, 1'b0);
      pulseReset();
      checkOutput("rst_out_drop", 32'(bus.b_valid), 32'd0);

      // Reset after three of four SUM operands, then a fresh SUM
      applyStimulus(1'b1, 32'h11, 3'd6, 1'b0);
      applyStimulus(1'b1, 32'h22, 3'd6, 1'b0);
      applyStimulus(1'b1, 32'h33, 3'd6, 1'b0);
      pulseReset();
      applyStimulus(1'b0, 32'h0, 3'd6, 1'b1);
      checkOutput("rst_mid_drop", 32'(bus.b_valid), 32'd0);
      for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 32'(i), 3'd6, 1'b0);
      waitResult("sum_after_rst", 32'd10, 0);
`ifdef OP_CALC_STATS_EN
      checkOutput("res_count_lit", 32'(res_count), 32'd1);
`endif

      applyStimulus(1'b0, 32'h0, 3'd0, 1'b0);
      applyStimulus(1'b0, 32'h0, 3'd0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
